// File: rtl/sync_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : sync_debouncer
// Brief    : Synchronizes a raw asynchronous input and debounces it into a
//            clean registered level, counting aborted transitions.
// Revision : 1.0 - initial release
// ============================================================================
module sync_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sig_in,
  input  logic                glitch_clr,
  output logic                db_out,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int                 C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_t;

  state_t               r_state;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;

  logic                 w_s;
  logic [C_CNT_W-1:0]   w_cnt_inc;
  logic                 w_abort;
  logic                 w_glitch_sat;

  // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign w_s          = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_abort      = (r_state == ST_QUALIFY) && (w_s == db_out);
  assign w_glitch_sat = &glitch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_STABLE;
      r_cnt      <= '0;
      db_out     <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      // Clear has priority over a coincident abort.
      if (glitch_clr) begin
        glitch_cnt <= '0;
      end else if (w_abort && !w_glitch_sat) begin
        glitch_cnt <= glitch_cnt + 1'b1;
      end

      case (r_state)
        ST_STABLE: begin
          if (w_s != db_out) begin
            if (DEBOUNCE_CYCLES == 1) begin
              db_out <= w_s;
            end else begin
              r_state <= ST_QUALIFY;
              r_cnt   <= C_CNT_ONE;
              busy    <= 1'b1;
            end
          end
        end
        ST_QUALIFY: begin
          if (w_s == db_out) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else if (w_cnt_inc == C_CNT_LAST) begin
            db_out  <= ~db_out;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_debouncer
// Brief    : Directed scoreboard bench for sync_debouncer (2 sync, 4 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_debouncer;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int GLITCH_W        = 8;
  localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int GMAX            = (1 << GLITCH_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                sig_in;
  logic                glitch_clr;
  logic                db_out;
  logic                busy;
  logic [GLITCH_W-1:0] glitch_cnt;

  sync_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .GLITCH_W       (GLITCH_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .glitch_clr(glitch_clr),
    .db_out    (db_out),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; outputs sampled at a negedge belong to edge ecount.
  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } exp_t;

  exp_t exp_q[$];
  exp_t tr_q[$];
  int   checks  = 0;
  int   errors  = 0;
  bit   done    = 1'b0;
  int   g_model = 0;

  function automatic string kname(input int k);
    case (k)
      0:       return "db_out";
      1:       return "busy";
      default: return "glitch_cnt";
    endcase
  endfunction

  task automatic expect_at(input int cyc, input int kind, input int val);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic expect_edge(input int cyc, input int val);
    exp_t e;
    e.cyc = cyc; e.kind = 0; e.val = val;
    tr_q.push_back(e);
  endtask

  // New level v first captured on edge e0+1: qualification runs edges e0+3..e0+LAT.
  task automatic qualify_checks(input int e0, input int v);
    expect_edge(e0 + LAT, v);
    expect_at(e0 + 2, 1, 0);
    for (int k = 3; k < LAT; k++) expect_at(e0 + k, 1, 1);
    expect_at(e0 + LAT, 1, 0);
    expect_at(e0 + LAT - 1, 0, 1 - v);
    expect_at(e0 + LAT, 0, v);
    expect_at(e0 + LAT, 2, g_model);
  endtask

  task automatic step(input int v);
    int e0;
    e0 = ecount;
    sig_in = v[0];
    qualify_checks(e0, v);
    repeat (LAT + 2) @(negedge clk);
  endtask

  // High pulse of n (<DEBOUNCE_CYCLES) cycles from db_out=0: abort lands on edge e0+n+3.
  task automatic glitch(input int n, input bit clr);
    int e0;
    int g_prev;
    e0 = ecount;
    g_prev = g_model;
    sig_in = 1'b1;
    repeat (n) @(negedge clk);
    sig_in = 1'b0;
    g_model = clr ? 0 : ((g_model < GMAX) ? g_model + 1 : GMAX);
    expect_at(e0 + n + 2, 1, 1);
    expect_at(e0 + n + 2, 2, g_prev);
    expect_at(e0 + n + 3, 1, 0);
    expect_at(e0 + n + 3, 0, 0);
    expect_at(e0 + n + 3, 2, g_model);
    repeat (2) @(negedge clk);
    if (clr) glitch_clr = 1'b1;
    @(negedge clk);
    glitch_clr = 1'b0;
    @(negedge clk);
  endtask

  // Stimulus
  initial begin
    int e0;
    int e1;
    rst_n      = 1'b0;
    sig_in     = 1'b1;
    glitch_clr = 1'b0;

    // Reset held with input high
    @(negedge clk);
    e0 = ecount;
    for (int k = 1; k <= 3; k++) begin
      expect_at(e0 + k, 0, 0);
      expect_at(e0 + k, 1, 0);
      expect_at(e0 + k, 2, 0);
    end
    repeat (4) @(negedge clk);
    e0 = ecount;
    rst_n = 1'b1;
    qualify_checks(e0, 1);
    repeat (LAT + 2) @(negedge clk);

    // Clean steps
    step(0);
    step(1);
    step(0);

    // Single glitch
    glitch(3, 1'b0);

    // Bounce train ending high
    e0 = ecount;
    expect_at(e0 + 5, 2, g_model + 1);
    expect_at(e0 + 9, 2, g_model + 2);
    expect_at(e0 + 13, 0, 0);
    expect_edge(e0 + 14, 1);
    g_model = g_model + 2;
    sig_in = 1'b1; repeat (2) @(negedge clk);
    sig_in = 1'b0; repeat (2) @(negedge clk);
    sig_in = 1'b1; repeat (2) @(negedge clk);
    sig_in = 1'b0; repeat (2) @(negedge clk);
    sig_in = 1'b1; repeat (8) @(negedge clk);
    expect_at(ecount + 2, 2, g_model);
    repeat (8) @(negedge clk);
    step(0);

    // Saturation, clear coincident with abort, then count resumes
    for (int i = 0; i < 260; i++) glitch(2, 1'b0);
    glitch(2, 1'b1);
    glitch(2, 1'b0);

    // Asynchronous reset while qualifying
    e0 = ecount;
    sig_in = 1'b1;
    expect_at(e0 + 3, 1, 1);
    expect_at(e0 + 4, 1, 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    g_model = 0;
    e1 = ecount;
    expect_at(e1, 0, 0);
    expect_at(e1, 1, 0);
    expect_at(e1, 2, 0);
    repeat (3) @(negedge clk);
    e0 = ecount;
    rst_n = 1'b1;
    qualify_checks(e0, 1);
    repeat (LAT + 4) @(negedge clk);

    done = 1'b1;
  end

  // Monitor / scoreboard
  logic prev_db = 1'b0;
  always @(negedge clk) begin
    exp_t keep[$];
    exp_t t;
    int   got;
    if (db_out !== prev_db) begin
      checks++;
      if (tr_q.size() == 0) begin
        errors++;
        $display("FAIL db_out_edge: unexpected change to %0b at edge %0d, required no change", db_out, ecount);
      end else begin
        t = tr_q.pop_front();
        if (t.cyc != ecount || t.val != int'(db_out)) begin
          errors++;
          $display("FAIL db_out_edge: got %0b at edge %0d, required %0d at edge %0d",
                   db_out, ecount, t.val, t.cyc);
        end
      end
    end
    prev_db = db_out;

    keep = {};
    foreach (exp_q[i]) begin
      if (exp_q[i].cyc > ecount) begin
        keep.push_back(exp_q[i]);
      end else begin
        checks++;
        case (exp_q[i].kind)
          0:       got = int'(db_out);
          1:       got = int'(busy);
          default: got = int'(glitch_cnt);
        endcase
        if (exp_q[i].cyc < ecount || got != exp_q[i].val) begin
          errors++;
          $display("FAIL %s: edge %0d got %0d, required %0d at edge %0d",
                   kname(exp_q[i].kind), ecount, got, exp_q[i].val, exp_q[i].cyc);
        end
      end
    end
    exp_q = keep;

    if (done) begin
      checks++;
      if (tr_q.size() != 0) begin
        errors++;
        $display("FAIL db_out_edge: %0d expected transitions never seen, first due at edge %0d",
                 tr_q.size(), tr_q[0].cyc);
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL pending_checks: %0d sample checks left unresolved, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
